// File: rtl/ts_packet_packer.sv
// Transport-stream packer: aligns 10-bit stream bytes on sync-marked packet
// boundaries and packs four bytes per 32-bit word for the DDR write port.
module ts_packet_packer #(
   parameter int         PKT_LEN    = 188,
   parameter logic [7:0] SYNC_BYTE  = 8'h47,
   parameter logic [7:0] STUFF_BYTE = 8'hFF
) (
   input  logic        SYS_CLOCK,
   input  logic        SYS_RESET_N,
   input  logic        IN_VALID,
   input  logic [9:0]  IN_DATA,
   output logic        IN_READY,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_DATA,
   output logic        OUT_SOP,
   output logic        LOCKED,
   output logic [15:0] PKT_COUNT,
   output logic [15:0] ERR_COUNT
);

   localparam int IDX_W = $clog2(PKT_LEN + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   typedef enum logic {HUNT, PACKET} state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [2:0][7:0]     lane_reg, lane_next;
   logic                sop_reg, sop_next;
   logic                out_valid_reg, out_valid_next;
   logic [31:0]         out_data_reg, out_data_next;
   logic                out_sop_reg, out_sop_next;
   logic [15:0]         pkt_count_reg, pkt_count_next;
   logic [15:0]         err_count_reg, err_count_next;

   logic                byte_take;
   logic                ts_valid;
   logic                ts_sync;
   logic [7:0]          ts_byte;
   logic                is_start;
   logic [1:0]          lane_sel;
   logic                start_pkt;
   logic [31:0]         full_word;
   logic [31:0]         stuff_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign IN_READY  = !out_valid_reg || OUT_READY;
   assign byte_take = IN_VALID && IN_READY;
   assign ts_valid  = IN_DATA[9];
   assign ts_sync   = IN_DATA[8];
   assign ts_byte   = IN_DATA[7:0];
   assign is_start  = ts_sync && (ts_byte == SYNC_BYTE);
   assign lane_sel  = idx_reg[1:0];

   // Lane 0 sits in the top byte; lanes not yet filled are padded when a
   // packet is cut short.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         assign full_word[31-8*gi -: 8]  = lane_reg[gi];
         assign stuff_word[31-8*gi -: 8] = (lane_sel > 2'(gi)) ? lane_reg[gi] : STUFF_BYTE;
      end
   endgenerate
   assign full_word[7:0]  = ts_byte;
   assign stuff_word[7:0] = STUFF_BYTE;

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      lane_next      = lane_reg;
      sop_next       = sop_reg;
      out_valid_next = out_valid_reg && !OUT_READY;
      out_data_next  = out_data_reg;
      out_sop_next   = out_sop_reg;
      pkt_count_next = pkt_count_reg;
      err_count_next = err_count_reg;
      start_pkt      = 1'b0;

      if (byte_take && ts_valid) begin
         case (state_reg)
            HUNT: start_pkt = is_start;
            PACKET: begin
               if (idx_reg == '0) begin
                  if (is_start) begin
                     start_pkt = 1'b1;
                  end else begin
                     err_count_next = sat_inc(err_count_reg);
                     state_next     = HUNT;
                  end
               end else if (ts_sync) begin
                  // Sync arrived before the packet was complete: flush any
                  // partially filled word, then restart or drop lock.
                  if (lane_sel != 2'd0) begin
                     out_valid_next = 1'b1;
                     out_data_next  = stuff_word;
                     out_sop_next   = sop_reg;
                  end
                  err_count_next = sat_inc(err_count_reg);
                  if (ts_byte == SYNC_BYTE) begin
                     start_pkt = 1'b1;
                  end else begin
                     state_next = HUNT;
                     idx_next   = '0;
                     sop_next   = 1'b0;
                  end
               end else begin
                  case (lane_sel)
                     2'd0: lane_next[0] = ts_byte;
                     2'd1: lane_next[1] = ts_byte;
                     2'd2: lane_next[2] = ts_byte;
                     default: begin
                        out_valid_next = 1'b1;
                        out_data_next  = full_word;
                        out_sop_next   = sop_reg;
                        sop_next       = 1'b0;
                     end
                  endcase
                  if (idx_reg == LAST_IDX) begin
                     pkt_count_next = sat_inc(pkt_count_reg);
                     idx_next       = '0;
                  end else begin
                     idx_next = idx_reg + IDX_W'(1);
                  end
               end
            end
            default: state_next = HUNT;
         endcase

         if (start_pkt) begin
            state_next   = PACKET;
            idx_next     = IDX_W'(1);
            lane_next[0] = SYNC_BYTE;
            sop_next     = 1'b1;
         end
      end
   end

   always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
      if (!SYS_RESET_N) begin
         state_reg     <= HUNT;
         idx_reg       <= '0;
         lane_reg      <= '0;
         sop_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sop_reg   <= 1'b0;
         pkt_count_reg <= '0;
         err_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         lane_reg      <= lane_next;
         sop_reg       <= sop_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_sop_reg   <= out_sop_next;
         pkt_count_reg <= pkt_count_next;
         err_count_reg <= err_count_next;
      end
   end

   assign OUT_VALID = out_valid_reg;
   assign OUT_DATA  = out_data_reg;
   assign OUT_SOP   = out_sop_reg;
   assign LOCKED    = (state_reg == PACKET);
   assign PKT_COUNT = pkt_count_reg;
   assign ERR_COUNT = err_count_reg;

endmodule

// File: tb/tb_ts_packet_packer.sv
// Directed + randomized bench for ts_packet_packer against a packet-level
// reference model that buffers whole packets and emits expected words.
module tb_ts_packet_packer;

   localparam int         PKT_LEN = 188;
   localparam logic [7:0] SYNC    = 8'h47;
   localparam logic [7:0] STUFF   = 8'hFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [9:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_sop;
   logic        locked;
   logic [15:0] pkt_count;
   logic [15:0] err_count;

   always #5 clk = ~clk;

   ts_packet_packer #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(SYNC), .STUFF_BYTE(STUFF)) dut (
      .SYS_CLOCK   (clk),
      .SYS_RESET_N (rst_n),
      .IN_VALID    (in_valid),
      .IN_DATA     (in_data),
      .IN_READY    (in_ready),
      .OUT_VALID   (out_valid),
      .OUT_READY   (out_ready),
      .OUT_DATA    (out_data),
      .OUT_SOP     (out_sop),
      .LOCKED      (locked),
      .PKT_COUNT   (pkt_count),
      .ERR_COUNT   (err_count)
   );

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] data;
      logic        sop;
   } word_t;

   word_t       exp_q[$];
   logic [31:0] got_q[$];
   logic        got_sop_q[$];
   int          words_seen = 0;
   int          stall_left = 0;

   // Reference model: packet byte buffer plus lock flag and counters.
   logic [7:0] m_bytes [PKT_LEN];
   bit         m_locked = 1'b0;
   int         m_len = 0;
   int         m_pkt = 0;
   int         m_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void push_word(input int first, input int n);
      word_t w;
      w.data = {4{STUFF}};
      for (int k = 0; k < n; k++) w.data[31-8*k -: 8] = m_bytes[first+k];
      w.sop = (first == 0);
      exp_q.push_back(w);
   endfunction

   function automatic void m_start();
      m_bytes[0] = SYNC;
      m_len      = 1;
      m_locked   = 1'b1;
   endfunction

   function automatic void model_byte(input logic [9:0] b);
      logic       sync;
      logic [7:0] d;
      sync = b[8];
      d    = b[7:0];
      if (!b[9]) return;
      if (!m_locked) begin
         if (sync && d == SYNC) m_start();
      end else if (m_len == 0) begin
         if (sync && d == SYNC) m_start();
         else begin
            m_err++;
            m_locked = 1'b0;
         end
      end else if (sync) begin
         if (m_len % 4 != 0) push_word(m_len - m_len % 4, m_len % 4);
         m_err++;
         if (d == SYNC) m_start();
         else begin
            m_locked = 1'b0;
            m_len    = 0;
         end
      end else begin
         m_bytes[m_len] = d;
         m_len++;
         if (m_len % 4 == 0) push_word(m_len - 4, 4);
         if (m_len == PKT_LEN) begin
            m_pkt++;
            m_len = 0;
         end
      end
   endfunction

   // One clock: drive at negedge, check just after, account for the handshake.
   task automatic cycle(input logic iv, input logic [9:0] id, input logic ordy, output logic consumed);
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || ordy));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("out_data", out_data, exp_q[0].data);
         chk("out_sop", 32'(out_sop), 32'(exp_q[0].sop));
      end
      chk("locked", 32'(locked), 32'(m_locked));
      chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (out_valid && ordy && exp_q.size() != 0) begin
         $display("word %0d data=%h sop=%b", words_seen, out_data, out_sop);
         got_q.push_back(out_data);
         got_sop_q.push_back(out_sop);
         void'(exp_q.pop_front());
         words_seen++;
      end
      consumed = iv && in_ready;
      if (consumed) model_byte(id);
   endtask

   task automatic send(input logic sync, input logic [7:0] d, input int idle_pct, input int stall_pct);
      logic c;
      logic rdy;
      bit   done = 1'b0;
      for (int a = 0; a < 200 && !done; a++) begin
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else begin
            rdy = ($urandom_range(99) >= stall_pct);
         end
         if ($urandom_range(99) < idle_pct) begin
            cycle($urandom_range(1), {1'b0, 9'($urandom)}, rdy, c);
         end else begin
            cycle(1'b1, {1'b1, sync, d}, rdy, c);
            done = c;
         end
      end
      if (!done) begin
         compared++;
         mismatched++;
         $error("FAIL send_timeout: observed no consume expected consume");
      end
   endtask

   task automatic drain();
      logic c;
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) cycle(1'b0, 10'h0, 1'b1, c);
      cycle(1'b0, 10'h0, 1'b1, c);
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic send_packet(input int nbytes, input bit counting, input int idle_pct, input int stall_pct);
      send(1'b1, SYNC, idle_pct, stall_pct);
      for (int i = 1; i < nbytes; i++)
         send(1'b0, counting ? 8'(i) : 8'($urandom), idle_pct, stall_pct);
   endtask

   task automatic clear_got();
      got_q.delete();
      got_sop_q.delete();
      words_seen = 0;
   endtask

   initial begin
      logic c;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_locked", 32'(locked), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean stream: two counting packets
      clear_got();
      send_packet(PKT_LEN, 1'b1, 0, 0);
      send_packet(PKT_LEN, 1'b1, 0, 0);
      drain();
      chk("clean_words", 32'(words_seen), 32'd94);
      if (got_q.size() > 0) begin
         chk("clean_word0", got_q[0], 32'h47010203);
         chk("clean_sop0", 32'(got_sop_q[0]), 32'h1);
      end
      chk("clean_pkt", 32'(pkt_count), 32'd2);
      chk("clean_locked", 32'(locked), 32'h1);

      // Asynchronous reset mid-packet
      send_packet(50, 1'b0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_out_data", out_data, 32'h0);
      chk("arst_out_sop", 32'(out_sop), 32'h0);
      chk("arst_locked", 32'(locked), 32'h0);
      chk("arst_pkt", 32'(pkt_count), 32'h0);
      chk("arst_err", 32'(err_count), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h1);
      exp_q.delete();
      m_locked = 1'b0;
      m_len = 0;
      m_pkt = 0;
      m_err = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Acquisition from garbage
      clear_got();
      for (int i = 0; i < 10; i++) send(1'b0, 8'($urandom), 0, 0);
      send(1'b1, 8'h12, 0, 0);
      drain();
      chk("garbage_words", 32'(words_seen), 32'd0);
      send_packet(PKT_LEN, 1'b0, 0, 0);
      drain();
      chk("acq_words", 32'(words_seen), 32'd47);
      chk("acq_err", 32'(err_count), 32'd0);

      // Backpressure with idle bytes interleaved
      clear_got();
      send(1'b1, SYNC, 20, 5);
      for (int i = 1; i < PKT_LEN; i++) begin
         if (i == 90) stall_left = 20;
         send(1'b0, 8'($urandom), 20, 5);
      end
      drain();
      chk("bp_words", 32'(words_seen), 32'd47);
      chk("bp_err", 32'(err_count), 32'd0);

      // Early sync at index 6
      clear_got();
      send(1'b1, SYNC, 0, 0);
      send(1'b0, 8'h01, 0, 0);
      send(1'b0, 8'h02, 0, 0);
      send(1'b0, 8'h03, 0, 0);
      send(1'b0, 8'hAA, 0, 0);
      send(1'b0, 8'hBB, 0, 0);
      send_packet(PKT_LEN, 1'b0, 0, 0);
      drain();
      if (got_q.size() > 2) begin
         chk("early_stuff", got_q[1], 32'hAABBFFFF);
         chk("early_stuff_sop", 32'(got_sop_q[1]), 32'h0);
         chk("early_new_sop", 32'(got_sop_q[2]), 32'h1);
      end
      chk("early_words", 32'(words_seen), 32'd49);
      chk("early_err", 32'(err_count), 32'd1);
      chk("early_pkt", 32'(pkt_count), 32'd3);

      // Lock loss after a complete packet, then relock
      send(1'b0, 8'h00, 0, 0);
      drain();
      chk("loss_locked", 32'(locked), 32'h0);
      chk("loss_err", 32'(err_count), 32'd2);
      send_packet(PKT_LEN, 1'b0, 0, 0);
      drain();
      chk("relock", 32'(locked), 32'h1);

      // Random soak: truncated packets, bad syncs, garbage, idles, stalls
      for (int s = 0; s < 12; s++) begin
         int len;
         len = ($urandom_range(2) == 0) ? PKT_LEN : $urandom_range(PKT_LEN - 1, 1);
         send_packet(len, 1'b0, 10, 15);
         if ($urandom_range(3) == 0) send(1'b1, 8'($urandom_range(255, 72)), 10, 15);
         if ($urandom_range(3) == 0)
            for (int g = 0; g < 5; g++) send(1'b0, 8'($urandom), 10, 15);
      end
      drain();
      cycle(1'b0, 10'h0, 1'b1, c);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ts_packet_packer.md
# ts_packet_packer

Sits between the stbToMem async FIFO read side and the DDR3 write port, in the 50 MHz SYS_CLOCK domain. Accepts 10-bit transport-stream bytes, aligns on 188-byte packet boundaries using the TS SYNC flag and 0x47 sync byte, and discards idle bytes and bytes outside a locked packet. Packs four stream bytes per 32-bit DDR word, so the recorder stores packets densely rather than one byte per word. Provides a valid/ready output plus lock status and packet/error counters for the LEDs.

## Interface
Parameters:
- PKT_LEN, 188: bytes per TS packet; must be a multiple of 4.
- SYNC_BYTE, 8'h47: required value of the first byte of each packet.
- STUFF_BYTE, 8'hFF: filler used to complete a truncated word.

Ports:
- SYS_CLOCK  in  1  50 MHz system clock; the only clock.
- SYS_RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  IN_DATA holds a byte (FIFO not empty).
- IN_DATA  in  10  {TS_VALID, TS_SYNC, TS_DATA[7:0]}.
- IN_READY  out  1  byte consumed this cycle when IN_VALID && IN_READY; drives the FIFO rdreq.
- OUT_VALID  out  1  OUT_DATA holds a packed word.
- OUT_READY  in  1  sink accepts the word (connected to !ddr_write_waitrequest).
- OUT_DATA  out  32  packed word; first byte in [31:24], last in [7:0].
- OUT_SOP  out  1  qualifies OUT_DATA as the first word of a packet.
- LOCKED  out  1  high while inside aligned packets.
- PKT_COUNT  out  16  complete packets emitted; saturates at 16'hFFFF.
- ERR_COUNT  out  16  truncated packets plus lock losses; saturates at 16'hFFFF.

## Operation
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - A byte is consumed when IN_VALID && IN_READY.
  - Consumed bytes with TS_VALID = 0 are discarded and change no state.
- States: HUNT (reset), PACKET.
- HUNT:
  - LOCKED = 0.
  - A consumed byte with TS_SYNC = 1 and TS_DATA = SYNC_BYTE moves to PACKET: lane 0 is loaded, byte index = 1, sop flag is set.
  - All other bytes are discarded.
- PACKET:
  - LOCKED = 1.
  - Each valid byte is written to lane index mod 4 of the assembly register and the index increments.
  - When lane 3 is written, the assembled word plus the sop flag are loaded into the output register and the sop flag clears.
  - When the index reaches PKT_LEN, PKT_COUNT increments and the index returns to 0.
- Index 0, the expected packet start:
  - A byte with TS_SYNC = 1 and TS_DATA = SYNC_BYTE starts the next packet, same as the HUNT entry.
  - Any other valid byte is dropped, ERR_COUNT increments, and the state returns to HUNT.
- Early sync, a byte with TS_SYNC = 1 at index 1..PKT_LEN-1:
  - Any lanes already filled in the current word are completed with STUFF_BYTE and that word is loaded to the output register.
  - ERR_COUNT increments and PKT_COUNT does not.
  - If TS_DATA = SYNC_BYTE, the byte starts a new packet in a fresh assembly word (index 1, sop set).
  - Otherwise the byte is dropped and the state returns to HUNT.
  - If the early sync arrives at a word boundary (index mod 4 = 0), no stuffed word is emitted.
- Reset mid-packet: all state and counters clear. A partial word or a pending output word is lost, with no flush.

## Timing
- Reset values:
  - OUT_VALID = 0, OUT_DATA = 0, OUT_SOP = 0.
  - LOCKED = 0, PKT_COUNT = 0, ERR_COUNT = 0.
  - State HUNT, index 0.
  - IN_READY = 1 after reset.
- Output timing:
  - OUT_VALID rises on the clock edge after the byte that completes a word, giving 1-cycle latency.
  - OUT_DATA and OUT_SOP stay stable while OUT_VALID && !OUT_READY.
- OUT_VALID && OUT_READY in the same cycle that a new word completes: OUT_VALID stays 1 and OUT_DATA takes the new word, with no bubble.
- Throughput: one byte per cycle while the sink keeps up; a full packet yields exactly PKT_LEN/4 = 47 words.
- LOCKED and the counters update on the edge after the triggering byte is consumed.
- Counter saturation: at 16'hFFFF the counter holds.

## Test plan
- Clean stream:
  - Stimulus: two back-to-back 188-byte packets, bytes 0x47,0x01,0x02,… with TS_SYNC on byte 0; OUT_READY = 1.
  - Response: 94 words; word 0 = 0x47010203 with OUT_SOP = 1; PKT_COUNT = 2; ERR_COUNT = 0; LOCKED = 1.
- Acquisition from garbage:
  - Stimulus: 10 random bytes, then a TS_SYNC byte of 0x12, then a valid packet.
  - Response: no output before the 0x47; 47 words emitted; ERR_COUNT = 0.
- Backpressure:
  - Stimulus: OUT_READY low for 20 cycles mid-packet.
  - Response: IN_READY low while a word is pending; OUT_DATA held stable; no byte lost or duplicated; packet content is bit-exact.
- Early sync:
  - Stimulus: sync+0x47 at index 6 (bytes 4,5 = 0xAA,0xBB).
  - Response: word 0xAABBFFFF emitted, then the new packet starts with OUT_SOP = 1; ERR_COUNT = 1; PKT_COUNT unchanged.
- Lock loss:
  - Stimulus: byte after 188 is 0x00 without TS_SYNC.
  - Response: LOCKED = 0, ERR_COUNT = 1; state returns to HUNT, and the next valid sync relocks.
- Idle and reset:
  - Stimulus: TS_VALID = 0 bytes interleaved within a packet.
  - Response: those bytes are ignored.
  - Stimulus: SYS_RESET_N pulsed low mid-packet.
  - Response: all outputs and counters read 0 immediately (asynchronous reset).
